// File: rtl/pattern_history_table.sv
// Pattern history table: 32 two-bit saturating counters indexed by local history,
// plus an in-order FIFO of in-flight predictions that trains counters on resolve.
module pattern_history_table #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     predict_req,
  input  logic [4:0]               predict_index,
  output logic                     stall,
  output logic                     predict_valid,
  output logic                     predict_taken,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  output logic                     mispredict,
  output logic                     resolve_err,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   inflight
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0] index;
    logic       pred;
  } entry_t;

  logic [1:0]    ctr_q [32];
  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          predict_valid_q, predict_taken_q;
  logic          mispredict_q, resolve_err_q;

  logic          accept;
  logic          empty;
  logic          pop;
  logic          pred_bit;
  entry_t        head_e;
  logic [1:0]    head_ctr;
  logic [1:0]    ctr_upd;

  // Stall looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign stall = (count_q == (PW+1)'(DEPTH));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    empty    = (count_q == '0);
    accept   = predict_req && !stall && !flush;
    pop      = resolve && !empty;
    pred_bit = ctr_q[predict_index][1];
    head_e   = fifo_q[head_q];
    head_ctr = ctr_q[head_e.index];
    ctr_upd  = head_ctr;
    if (resolve_taken) begin
      if (head_ctr != 2'b11) ctr_upd = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) ctr_upd = head_ctr - 2'b01;
    end

    tail_d  = accept ? tail_q + PW'(1) : tail_q;
    head_d  = pop    ? head_q + PW'(1) : head_q;
    count_d = count_q + (PW+1)'(accept) - (PW+1)'(pop);
    // Flush completes the pop above, then discards everything still queued.
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the counter array must be reset because its initial value defines the
      // first predictions; the FIFO payload below is guarded by occupancy and is not reset.
      for (int i = 0; i < 32; i++) ctr_q[i] <= 2'b01;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      predict_valid_q <= 1'b0;
      predict_taken_q <= 1'b0;
      mispredict_q    <= 1'b0;
      resolve_err_q   <= 1'b0;
    end else begin
      if (pop) ctr_q[head_e.index] <= ctr_upd;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      predict_valid_q <= accept;
      predict_taken_q <= accept && pred_bit;
      mispredict_q    <= pop && (head_e.pred != resolve_taken);
      resolve_err_q   <= resolve && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_q[tail_q] <= '{index: predict_index, pred: pred_bit};
  end

  assign predict_valid = predict_valid_q;
  assign predict_taken = predict_taken_q;
  assign mispredict    = mispredict_q;
  assign resolve_err   = resolve_err_q;
  assign inflight      = count_q;

endmodule

// File: tb/tb_pattern_history_table.sv
// Self-checking bench for pattern_history_table: behavioural model feeds a scoreboard
// of expected registered outputs, plus directed checks of the key corner cases.
module tb_pattern_history_table;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       predict_req;
  logic [4:0] predict_index;
  logic       stall;
  logic       predict_valid;
  logic       predict_taken;
  logic       resolve;
  logic       resolve_taken;
  logic       mispredict;
  logic       resolve_err;
  logic       flush;
  logic [$clog2(DEPTH):0] inflight;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0] idx;
    logic       pred;
  } m_ent_t;

  typedef struct {
    logic valid;
    logic taken;
    logic mis;
    logic err;
    int   infl;
  } exp_t;

  logic [1:0] m_ctr [32];
  m_ent_t     m_fifo [$];
  exp_t       sb [$];

  pattern_history_table #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .predict_req   (predict_req),
    .predict_index (predict_index),
    .stall         (stall),
    .predict_valid (predict_valid),
    .predict_taken (predict_taken),
    .resolve       (resolve),
    .resolve_taken (resolve_taken),
    .mispredict    (mispredict),
    .resolve_err   (resolve_err),
    .flush         (flush),
    .inflight      (inflight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ctr[i] = 2'b01;
    m_fifo.delete();
    sb.delete();
  endtask

  // One clock: drive at negedge, predict with the model, compare after the edge.
  task automatic step(input logic req, input logic [4:0] idx, input logic res,
                      input logic rt, input logic fl);
    exp_t   e;
    m_ent_t h;
    logic   exp_stall;
    logic   acc;
    logic   pbit;
    @(negedge clk);
    predict_req   = req;
    predict_index = idx;
    resolve       = res;
    resolve_taken = rt;
    flush         = fl;
    exp_stall = (m_fifo.size() == DEPTH);
    check("stall", stall, exp_stall);
    check("inflight_pre", inflight, m_fifo.size());
    acc  = req && !exp_stall && !fl;
    pbit = m_ctr[idx][1];
    e.mis = 1'b0;
    e.err = 1'b0;
    if (res && m_fifo.size() > 0) begin
      h = m_fifo.pop_front();
      e.mis = (h.pred != rt);
      if (rt && m_ctr[h.idx] != 2'b11) m_ctr[h.idx] = m_ctr[h.idx] + 2'b01;
      if (!rt && m_ctr[h.idx] != 2'b00) m_ctr[h.idx] = m_ctr[h.idx] - 2'b01;
    end else if (res) begin
      e.err = 1'b1;
    end
    if (acc) m_fifo.push_back('{idx: idx, pred: pbit});
    if (fl) m_fifo.delete();
    e.valid = acc;
    e.taken = pbit;
    e.infl  = m_fifo.size();
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("predict_valid", predict_valid, e.valid);
    if (e.valid) check("predict_taken", predict_taken, e.taken);
    check("mispredict", mispredict, e.mis);
    check("resolve_err", resolve_err, e.err);
    check("inflight", inflight, e.infl);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    predict_req = 1'b0; resolve = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    predict_index = 5'd0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_predict_valid", predict_valid, 1'b0);
    check("rst_predict_taken", predict_taken, 1'b0);
    check("rst_mispredict", mispredict, 1'b0);
    check("rst_resolve_err", resolve_err, 1'b0);
    check("rst_inflight", inflight, 0);
    check("rst_stall", stall, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    predict_req = 1'b0; predict_index = 5'd0;
    resolve = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    do_reset(2);

    // Reset defaults
    step(1, 5'h00, 0, 0, 0);
    check("dflt_valid", predict_valid, 1'b1);
    check("dflt_taken", predict_taken, 1'b0);
    check("dflt_inflight", inflight, 1);
    step(0, 5'h00, 1, 0, 0);

    // Saturating training on 0x15: 01 -> 10 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      step(1, 5'h15, 0, 0, 0);
      step(0, 5'h00, 1, 1, 0);
      check("train_mis", mispredict, (i == 0));
    end
    step(1, 5'h15, 0, 0, 0);
    check("trained_taken", predict_taken, 1'b1);
    step(0, 5'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'h15, 0, 0, 0);
      step(0, 5'h00, 1, 0, 0);
    end
    step(1, 5'h15, 0, 0, 0);
    check("untrained_taken", predict_taken, 1'b0);
    step(0, 5'h00, 1, 1, 0);

    // Full FIFO: refused push with simultaneous resolve, then accepted
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 0, 0, 0);
    check("full_stall", stall, 1'b1);
    check("full_inflight", inflight, 4);
    step(1, 5'h05, 1, 0, 0);
    check("refused_valid", predict_valid, 1'b0);
    check("refused_inflight", inflight, 3);
    step(1, 5'h05, 0, 0, 0);
    check("after_full_valid", predict_valid, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 5'h00, 1, 1, 0);

    // Empty resolve
    step(0, 5'h00, 1, 1, 0);
    check("empty_err", resolve_err, 1'b1);
    check("empty_mis", mispredict, 1'b0);
    step(0, 5'h00, 0, 0, 0);
    check("empty_err_pulse", resolve_err, 1'b0);

    // Flush race: head at 0x06 predicted 0, resolved taken during flush
    step(1, 5'h06, 0, 0, 0);
    step(1, 5'h07, 0, 0, 0);
    step(1, 5'h08, 0, 0, 0);
    step(1, 5'h09, 1, 1, 1);
    check("flush_mis", mispredict, 1'b1);
    check("flush_inflight", inflight, 0);
    check("flush_valid", predict_valid, 1'b0);
    step(1, 5'h06, 0, 0, 0);
    check("flush_trained", predict_taken, 1'b1);
    step(0, 5'h00, 1, 1, 0);

    // Same-index read/update on 0x0A with counter at 10
    step(1, 5'h0A, 0, 0, 0);
    step(0, 5'h00, 1, 1, 0);
    step(1, 5'h0A, 0, 0, 0);
    step(1, 5'h0A, 1, 0, 0);
    check("same_idx_pre", predict_taken, 1'b1);
    check("same_idx_mis", mispredict, 1'b1);
    step(1, 5'h0A, 0, 0, 0);
    check("same_idx_post", predict_taken, 1'b0);
    step(0, 5'h00, 1, 0, 0);
    step(0, 5'h00, 1, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    end

    // Reset in mid-flight
    step(1, 5'h15, 0, 0, 0);
    step(1, 5'h03, 0, 0, 0);
    do_reset(1);
    step(1, 5'h03, 0, 0, 0);
    check("post_rst_taken", predict_taken, 1'b0);
    check("post_rst_inflight", inflight, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_history_table.md
# pattern_history_table

Consumer side of the per-PC branch history: takes the 5-bit local history pattern produced by the history table and turns it into a taken/not-taken prediction. It also retires that prediction when the branch resolves. The block holds 32 two-bit saturating counters indexed by history pattern, plus an in-order FIFO of in-flight predictions. When the pipeline resolves a branch, the counter that produced the prediction is trained and a mispredict is flagged. It sits in fetch/decode, beside the history table, and is fed by its `out` port.

## Interface
Parameters:
- DEPTH, 4, in-flight FIFO entries (power of two, 2..16)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- predict_req  in  1  fetch requests a prediction this cycle
- predict_index  in  lc3b_p_index (5)  history pattern, from history table `out`
- stall  out  1  FIFO full; a predict_req this cycle is refused
- predict_valid  out  1  registered; accepted request from previous cycle
- predict_taken  out  1  registered; prediction for that request
- resolve  in  1  oldest in-flight branch resolved this cycle
- resolve_taken  in  1  actual outcome of that branch
- mispredict  out  1  registered; previous-cycle resolve disagreed with its prediction
- resolve_err  out  1  registered; previous-cycle resolve arrived with FIFO empty
- flush  in  1  discard all in-flight entries
- inflight  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = bit 1.
- **Reset (reset_n=0 at an edge):**
  - All 32 counters become 01.
  - FIFO is emptied; inflight=0.
  - predict_valid, predict_taken, mispredict and resolve_err are 0.
  - Reset overrides every other input, including mid-flight entries.
- **Predict:**
  - A request is accepted when predict_req=1, stall=0 and flush=0.
  - On acceptance, the current counter[predict_index] is read. Entry {index, predicted bit} is pushed at the tail.
  - predict_valid=1 next cycle, with predict_taken = that bit.
  - If the request is refused, predict_valid=0 next cycle and nothing is pushed.
- **stall** = (inflight == DEPTH). It depends only on registered occupancy.
  - A resolve in the same cycle does not free the slot for a same-cycle push.
- **Resolve with FIFO non-empty:**
  - The head entry is popped.
  - counter[head.index] increments (saturating at 11) if resolve_taken=1, else decrements (saturating at 00).
  - mispredict = (head.predicted != resolve_taken), registered.
- **Resolve with FIFO empty:** no counter change, resolve_err=1 next cycle, mispredict=0.
- **Same-cycle predict and resolve touching the same counter:** the prediction uses the pre-update value (no bypass). The update still lands.
- **Same-cycle push and pop:** occupancy is unchanged. The pushed entry goes behind all existing entries.
- **Flush:**
  - A same-cycle resolve is fully processed first (pop, train, mispredict).
  - Then the FIFO is emptied: head=tail, inflight=0.
  - A same-cycle predict_req is dropped and predict_valid=0 next cycle.
- **Pointers:** wrap modulo DEPTH. inflight distinguishes full from empty.
- **Single-cycle outputs:** mispredict, resolve_err and predict_valid are one-cycle pulses per event. Each returns to 0 unless re-triggered.

## Timing
- **Prediction latency:** 1 cycle, request edge to predict_valid/predict_taken.
- **Counter update:** visible to a read in the cycle after the resolve edge.
- **Mispredict and resolve_err latency:** 1 cycle after resolve.
- **inflight:** registered, updated at the same edge as push/pop/flush.
- **Throughput:** one push and one pop per cycle sustained. There are no combinational paths from predict_req or resolve to stall.
- **First cycle after reset deasserts:** requests are accepted. All predictions read not-taken until trained.

## Test plan
- **Reset defaults:** hold reset_n=0 for 2 cycles, release, then predict index 0x00.
  - predict_valid=1, predict_taken=0, inflight=1.
- **Saturating training:** on index 0x15, repeat predict then resolve taken 3 times, then predict.
  - predict_taken=1.
  - mispredict pulses only on the first resolve (01→10→11→11).
  - Then 4 not-taken resolves drive the counter to 00.
- **Full FIFO with DEPTH=4:**
  - Push 4 requests: stall=1, inflight=4.
  - A 5th request with simultaneous resolve: push refused, predict_valid=0 next cycle, inflight=3.
  - Next cycle: accepted.
- **Empty resolve:** resolve=1 with inflight=0.
  - resolve_err=1 for one cycle, mispredict=0, counters unchanged.
- **Flush race:** 3 in flight, head predicted 0. In one cycle assert flush, resolve_taken=1 and predict_req.
  - mispredict=1, inflight=0, predict_valid=0.
  - Head counter is incremented.
- **Same-index read/update:** counter[0x0A]=10. Resolve not-taken for a head at 0x0A in the same cycle as a predict on 0x0A.
  - The predict returns 1.
  - The following predict returns 0.
